// File: rtl/fp_add_align_stage_pkg.sv
`default_nettype none
// fp_add_align_stage_pkg: float format and alignment helpers shared by the FP add align stage.
// Rev 1.0
package fp_add_align_stage_pkg;

  localparam int C_DEF_EXP_WIDTH = 8;
  localparam int C_DEF_SIG_WIDTH = 23;

  // Default (binary32) view; modules re-declare the same layout with their own widths.
  typedef struct packed {
    logic                       sign;
    logic [C_DEF_EXP_WIDTH-1:0] exponent;
    logic [C_DEF_SIG_WIDTH-1:0] significand;
  } fp_default_t;

  // Beyond this many places every significand bit already sits below the sticky position.
  function automatic int max_align_shift(input int sig_width);
    return sig_width + 4;
  endfunction

  function automatic int align_shift_width(input int sig_width);
    return $clog2(max_align_shift(sig_width) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_align_stage_if.sv
`default_nettype none
// fp_add_align_stage_if: operand/result bundle with valid/ready handshake for the align stage.
// Rev 1.0
interface fp_add_align_stage_if
  import fp_add_align_stage_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int TAG_WIDTH = 8
);
  localparam int FW  = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int SW  = SIG_WIDTH + 1;
  localparam int SHW = align_shift_width(SIG_WIDTH);

  logic                        i_valid;
  logic                        i_ready;
  logic                        i_subtract;
  logic [NUM_LANES-1:0]        i_mask;
  logic [TAG_WIDTH-1:0]        i_tag;
  logic [NUM_LANES*FW-1:0]     i_operand1;
  logic [NUM_LANES*FW-1:0]     i_operand2;
  logic                        o_valid;
  logic                        o_ready;
  logic [NUM_LANES-1:0]        o_mask;
  logic [TAG_WIDTH-1:0]        o_tag;
  logic [NUM_LANES*SW-1:0]     o_significand_le;
  logic [NUM_LANES*SW-1:0]     o_significand_se;
  logic [NUM_LANES*SHW-1:0]    o_align_shift;
  logic [NUM_LANES-1:0]        o_sticky;
  logic [NUM_LANES*EXP_WIDTH-1:0] o_exponent;
  logic [NUM_LANES-1:0]        o_logical_subtract;
  logic [NUM_LANES-1:0]        o_result_sign;
  logic [NUM_LANES-1:0]        o_result_nan;
  logic [NUM_LANES-1:0]        o_result_inf;

  modport master (
    output i_valid, i_subtract, i_mask, i_tag, i_operand1, i_operand2, o_ready,
    input  i_ready, o_valid, o_mask, o_tag, o_significand_le, o_significand_se,
           o_align_shift, o_sticky, o_exponent, o_logical_subtract, o_result_sign,
           o_result_nan, o_result_inf
  );

  modport slave (
    input  i_valid, i_subtract, i_mask, i_tag, i_operand1, i_operand2, o_ready,
    output i_ready, o_valid, o_mask, o_tag, o_significand_le, o_significand_se,
           o_align_shift, o_sticky, o_exponent, o_logical_subtract, o_result_sign,
           o_result_nan, o_result_inf
  );

endinterface
`default_nettype wire

// File: rtl/fp_add_align_stage_lane.sv
`default_nettype none
// fp_align_lane: per-lane classify, magnitude swap, alignment shift and sticky (combinational).
// Rev 1.0
module fp_align_lane
  import fp_add_align_stage_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  localparam int FW        = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int SW        = SIG_WIDTH + 1,
  localparam int MAX_SHIFT = max_align_shift(SIG_WIDTH),
  localparam int SHW       = align_shift_width(SIG_WIDTH)
) (
  input  wire logic [FW-1:0]        operand1,
  input  wire logic [FW-1:0]        operand2,
  input  wire logic                 subtract,
  output logic      [SW-1:0]        significand_le,
  output logic      [SW-1:0]        significand_se,
  output logic      [SHW-1:0]       align_shift,
  output logic                      sticky,
  output logic      [EXP_WIDTH-1:0] exponent,
  output logic                      logical_subtract,
  output logic                      result_sign,
  output logic                      result_nan,
  output logic                      result_inf
);

  typedef struct packed {
    logic                 sign;
    logic [EXP_WIDTH-1:0] exponent;
    logic [SIG_WIDTH-1:0] significand;
  } fp_t;

  fp_t                  w_a;
  fp_t                  w_b;
  logic                 w_op1_larger;
  logic [SW-1:0]        w_full1;
  logic [SW-1:0]        w_full2;
  logic [EXP_WIDTH-1:0] w_diff;
  logic [31:0]          w_diff32;
  logic [SW-1:0]        w_lost_mask;
  logic                 w_inf1;
  logic                 w_inf2;
  logic                 w_nan1;
  logic                 w_nan2;

  assign w_a = fp_t'(operand1);
  assign w_b = fp_t'(operand2);

  assign w_full1 = {(|w_a.exponent), w_a.significand};
  assign w_full2 = {(|w_b.exponent), w_b.significand};

  assign w_op1_larger = (w_a.exponent > w_b.exponent) ||
                        ((w_a.exponent == w_b.exponent) && (w_a.significand >= w_b.significand));

  assign w_inf1 = (&w_a.exponent) && (w_a.significand == '0);
  assign w_inf2 = (&w_b.exponent) && (w_b.significand == '0);
  assign w_nan1 = (&w_a.exponent) && (w_a.significand != '0);
  assign w_nan2 = (&w_b.exponent) && (w_b.significand != '0);

  always_comb begin
    w_diff      = w_op1_larger ? (w_a.exponent - w_b.exponent) : (w_b.exponent - w_a.exponent);
    w_diff32    = 32'(w_diff);
    // Bit i of se falls below the round position once the shift reaches i+3.
    w_lost_mask = '0;
    for (int i = 0; i < SW; i++) begin
      w_lost_mask[i] = (w_diff32 >= 32'(i + 3));
    end
  end

  assign logical_subtract = w_a.sign ^ w_b.sign ^ subtract;
  assign significand_le   = w_op1_larger ? w_full1 : w_full2;
  assign significand_se   = w_op1_larger ? w_full2 : w_full1;
  assign exponent         = w_op1_larger ? w_a.exponent : w_b.exponent;
  assign result_sign      = w_op1_larger ? w_a.sign : (w_b.sign ^ subtract);
  assign align_shift      = (w_diff32 > 32'(MAX_SHIFT)) ? SHW'(MAX_SHIFT) : SHW'(w_diff32);
  assign sticky           = |(significand_se & w_lost_mask);
  assign result_nan       = w_nan1 || w_nan2 || (w_inf1 && w_inf2 && logical_subtract);
  assign result_inf       = !result_nan && (w_inf1 || w_inf2);

endmodule
`default_nettype wire

// File: rtl/fp_add_align_stage.sv
`default_nettype none
// fp_add_align_stage: NUM_LANES align lanes behind a registered output with a one-entry skid buffer.
// Rev 1.0
module fp_add_align_stage
  import fp_add_align_stage_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int TAG_WIDTH = 8
) (
  input wire logic       clk,
  input wire logic       reset,
  fp_add_align_stage_if.slave bus
);

  localparam int FW  = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int SW  = SIG_WIDTH + 1;
  localparam int SHW = align_shift_width(SIG_WIDTH);

  typedef struct packed {
    logic [NUM_LANES-1:0]           mask;
    logic [TAG_WIDTH-1:0]           tag;
    logic [NUM_LANES*SW-1:0]        sig_le;
    logic [NUM_LANES*SW-1:0]        sig_se;
    logic [NUM_LANES*SHW-1:0]       shift;
    logic [NUM_LANES-1:0]           sticky;
    logic [NUM_LANES*EXP_WIDTH-1:0] exponent;
    logic [NUM_LANES-1:0]           lsub;
    logic [NUM_LANES-1:0]           sign;
    logic [NUM_LANES-1:0]           nan;
    logic [NUM_LANES-1:0]           inf;
  } beat_t;

  beat_t w_beat;
  beat_t r_out;
  beat_t r_skid;
  logic  r_out_valid;
  logic  r_skid_valid;
  logic  r_in_ready;
  logic  w_in_fire;
  logic  w_out_drain;

  assign w_beat.mask = bus.i_mask;
  assign w_beat.tag  = bus.i_tag;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fp_align_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .SIG_WIDTH (SIG_WIDTH)
    ) u_lane (
      .operand1         (bus.i_operand1[l*FW +: FW]),
      .operand2         (bus.i_operand2[l*FW +: FW]),
      .subtract         (bus.i_subtract),
      .significand_le   (w_beat.sig_le[l*SW +: SW]),
      .significand_se   (w_beat.sig_se[l*SW +: SW]),
      .align_shift      (w_beat.shift[l*SHW +: SHW]),
      .sticky           (w_beat.sticky[l]),
      .exponent         (w_beat.exponent[l*EXP_WIDTH +: EXP_WIDTH]),
      .logical_subtract (w_beat.lsub[l]),
      .result_sign      (w_beat.sign[l]),
      .result_nan       (w_beat.nan[l]),
      .result_inf       (w_beat.inf[l])
    );
  end

  assign w_in_fire   = bus.i_valid && r_in_ready;
  assign w_out_drain = !r_out_valid || bus.o_ready;

  // i_ready mirrors !skid_valid but is its own flop so it never depends on o_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else if (w_out_drain) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out       <= w_beat;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
      r_in_ready <= 1'b1;
    end else if (w_in_fire) begin
      r_skid       <= w_beat;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign bus.i_ready            = r_in_ready;
  assign bus.o_valid            = r_out_valid;
  assign bus.o_mask             = r_out.mask;
  assign bus.o_tag              = r_out.tag;
  assign bus.o_significand_le   = r_out.sig_le;
  assign bus.o_significand_se   = r_out.sig_se;
  assign bus.o_align_shift      = r_out.shift;
  assign bus.o_sticky           = r_out.sticky;
  assign bus.o_exponent         = r_out.exponent;
  assign bus.o_logical_subtract = r_out.lsub;
  assign bus.o_result_sign      = r_out.sign;
  assign bus.o_result_nan       = r_out.nan;
  assign bus.o_result_inf       = r_out.inf;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_align_stage.sv
`default_nettype none
// tb_fp_add_align_stage: directed vectors, arithmetic reference model and per-cycle scoreboard.
// Rev 1.0
module tb_fp_add_align_stage;

  localparam int NL   = 4;
  localparam int E    = 8;
  localparam int S    = 23;
  localparam int TW   = 8;
  localparam int FW   = 1 + E + S;
  localparam int SW   = S + 1;
  localparam int MAXS = S + 4;
  localparam int SHW  = $clog2(MAXS + 1);
  localparam int NV   = 12;

  typedef struct packed {
    logic [SW-1:0]  le;
    logic [SW-1:0]  se;
    logic [SHW-1:0] shift;
    logic           sticky;
    logic [E-1:0]   exponent;
    logic           lsub;
    logic           sign;
    logic           nan;
    logic           inf;
  } lane_t;

  typedef struct packed {
    logic [NL-1:0]     mask;
    logic [TW-1:0]     tag;
    logic [NL*SW-1:0]  le;
    logic [NL*SW-1:0]  se;
    logic [NL*SHW-1:0] shift;
    logic [NL-1:0]     sticky;
    logic [NL*E-1:0]   exponent;
    logic [NL-1:0]     lsub;
    logic [NL-1:0]     sign;
    logic [NL-1:0]     nan;
    logic [NL-1:0]     inf;
  } beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [FW-1:0] vec_a   [NV];
  logic [FW-1:0] vec_b   [NV];
  logic          vec_sub [NV];
  lane_t         vec_exp [NV];
  beat_t         q[$];

  fp_add_align_stage_if #(.NUM_LANES(NL), .EXP_WIDTH(E), .SIG_WIDTH(S), .TAG_WIDTH(TW)) bus ();

  fp_add_align_stage #(.NUM_LANES(NL), .EXP_WIDTH(E), .SIG_WIDTH(S), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic lane_t lane_model(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic sub);
    lane_t  r;
    int     e1, e2, d, k, emax;
    longint m1, m2, f1, f2, mag1, mag2, le, se;
    logic   s1, s2, larger, inf1, inf2, nan1, nan2;
    emax = (1 << E) - 1;
    s1 = a[FW-1];
    s2 = b[FW-1];
    e1 = int'(a[FW-2:S]);
    e2 = int'(b[FW-2:S]);
    m1 = longint'(a[S-1:0]);
    m2 = longint'(b[S-1:0]);
    f1 = m1 + ((e1 != 0) ? (longint'(1) << S) : 0);
    f2 = m2 + ((e2 != 0) ? (longint'(1) << S) : 0);
    mag1 = longint'(e1) * (longint'(1) << S) + m1;
    mag2 = longint'(e2) * (longint'(1) << S) + m2;
    larger = (mag1 >= mag2);
    d  = (e1 > e2) ? e1 - e2 : e2 - e1;
    le = larger ? f1 : f2;
    se = larger ? f2 : f1;
    r.le       = SW'(le);
    r.se       = SW'(se);
    r.shift    = SHW'((d > MAXS) ? MAXS : d);
    r.exponent = E'(larger ? e1 : e2);
    r.lsub     = s1 ^ s2 ^ sub;
    r.sign     = larger ? s1 : (s2 ^ sub);
    if (d < 3) begin
      r.sticky = 1'b0;
    end else begin
      k = d - 2;
      r.sticky = (k > S) ? (se != 0) : ((se % (longint'(1) << k)) != 0);
    end
    inf1 = (e1 == emax) && (m1 == 0);
    inf2 = (e2 == emax) && (m2 == 0);
    nan1 = (e1 == emax) && (m1 != 0);
    nan2 = (e2 == emax) && (m2 != 0);
    r.nan = nan1 || nan2 || (inf1 && inf2 && r.lsub);
    r.inf = !r.nan && (inf1 || inf2);
    return r;
  endfunction

  function automatic beat_t model(input logic [NL-1:0] m, input logic [TW-1:0] t, input logic sub,
                                 input logic [NL*FW-1:0] a, input logic [NL*FW-1:0] b);
    beat_t r;
    lane_t l;
    r.mask = m;
    r.tag  = t;
    for (int i = 0; i < NL; i++) begin
      l = lane_model(a[i*FW +: FW], b[i*FW +: FW], sub);
      r.le[i*SW +: SW]      = l.le;
      r.se[i*SW +: SW]      = l.se;
      r.shift[i*SHW +: SHW] = l.shift;
      r.sticky[i]           = l.sticky;
      r.exponent[i*E +: E]  = l.exponent;
      r.lsub[i]             = l.lsub;
      r.sign[i]             = l.sign;
      r.nan[i]              = l.nan;
      r.inf[i]              = l.inf;
    end
    return r;
  endfunction

  function automatic beat_t dut_beat();
    beat_t r;
    r.mask     = bus.o_mask;
    r.tag      = bus.o_tag;
    r.le       = bus.o_significand_le;
    r.se       = bus.o_significand_se;
    r.shift    = bus.o_align_shift;
    r.sticky   = bus.o_sticky;
    r.exponent = bus.o_exponent;
    r.lsub     = bus.o_logical_subtract;
    r.sign     = bus.o_result_sign;
    r.nan      = bus.o_result_nan;
    r.inf      = bus.o_result_inf;
    return r;
  endfunction

  task automatic set_vec(input int idx, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [23:0] le, input logic [23:0] se, input int sh, input logic st,
                         input logic [7:0] ex, input logic ls, input logic sg, input logic nn, input logic nf);
    lane_t x;
    vec_a[idx]   = a;
    vec_b[idx]   = b;
    vec_sub[idx] = sub;
    x.le = le; x.se = se; x.shift = SHW'(sh); x.sticky = st; x.exponent = ex;
    x.lsub = ls; x.sign = sg; x.nan = nn; x.inf = nf;
    vec_exp[idx] = x;
  endtask

  // Scoreboard: every cycle with o_valid the head of the queue must be on the outputs.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
    end else begin
      if (bus.o_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got %h, required no beat", dut_beat());
        end else if (dut_beat() !== q[0]) begin
          bad++;
          $display("FAIL beat_tag%0d: got %h, required %h", q[0].tag, dut_beat(), q[0]);
        end
        if (bus.o_ready && q.size() != 0) void'(q.pop_front());
      end
      if (bus.i_valid && bus.i_ready)
        q.push_back(model(bus.i_mask, bus.i_tag, bus.i_subtract, bus.i_operand1, bus.i_operand2));
    end
  end

  task automatic send(input int j, input logic [TW-1:0] tag);
    logic [NL*FW-1:0] a, b;
    logic             accepted;
    int               n;
    for (int k = 0; k < NL; k++) begin
      a[k*FW +: FW] = vec_a[(j + k) % NV];
      b[k*FW +: FW] = vec_b[(j + k) % NV];
    end
    bus.i_operand1 = a;
    bus.i_operand2 = b;
    bus.i_subtract = vec_sub[j % NV];
    bus.i_mask     = NL'(j * 5 + 1);
    bus.i_tag      = tag;
    bus.i_valid    = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 50) begin
      @(negedge clk);
      accepted = bus.i_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout tag%0d: i_ready stayed 0, required 1 within 50 cycles", tag);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if (dut_beat() !== '0) begin
      bad++;
      $display("FAIL %s: outputs %h, required all zero", name, dut_beat());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    lane_t got;
    set_vec(0,  32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 0,  1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(1,  32'h3F800000, 32'h3D400001, 1'b0, 24'h800000, 24'hC00001, 5,  1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(2,  32'h3F800000, 32'h3D400000, 1'b0, 24'h800000, 24'hC00000, 5,  1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(3,  32'h3F800000, 32'h30800000, 1'b0, 24'h800000, 24'h800000, 27, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(4,  32'h3F800000, 32'h40000000, 1'b1, 24'h800000, 24'h800000, 1,  1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    set_vec(5,  32'h7F800000, 32'h7F800000, 1'b1, 24'h800000, 24'h800000, 0,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    set_vec(6,  32'h7F800000, 32'h7F800000, 1'b0, 24'h800000, 24'h800000, 0,  1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    set_vec(7,  32'h7FC00000, 32'h3F800000, 1'b0, 24'hC00000, 24'h800000, 27, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    set_vec(8,  32'h00000001, 32'h00000000, 1'b0, 24'h000001, 24'h000000, 0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(9,  32'hBF800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 0,  1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    set_vec(10, 32'h3F800000, 32'h3E000001, 1'b0, 24'h800000, 24'h800001, 3,  1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    set_vec(11, 32'h3F800000, 32'h3E800001, 1'b0, 24'h800000, 24'h800001, 2,  1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pin the reference model to hand-computed lane results.
    for (int v = 0; v < NV; v++) begin
      got = lane_model(vec_a[v], vec_b[v], vec_sub[v]);
      total++;
      if (got !== vec_exp[v]) begin
        bad++;
        $display("FAIL model_vec%0d: got %h, required %h", v, got, vec_exp[v]);
      end
    end

    bus.i_valid    = 1'b0;
    bus.i_subtract = 1'b0;
    bus.i_mask     = '0;
    bus.i_tag      = '0;
    bus.i_operand1 = '0;
    bus.i_operand2 = '0;
    bus.o_ready    = 1'b1;

    #3 reset = 1'b0;
    #1;
    check_bit("reset_o_valid", bus.o_valid, 1'b0);
    check_outputs_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_bit("i_ready_after_release", bus.i_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed vectors back to back with the output always draining.
    for (int j = 0; j < NV; j++) send(j, TW'(j + 16));
    repeat (3) @(posedge clk);
    #1;

    // Stall for three cycles: two beats are taken, then i_ready drops until drain.
    bus.o_ready = 1'b0;
    fork
      begin
        for (int t = 1; t <= 4; t++) send(t + 2, TW'(t));
      end
      begin
        repeat (3) @(negedge clk);
        check_bit("i_ready_after_two_accepts", bus.i_ready, 1'b0);
        @(posedge clk);
        #1 bus.o_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Fill output register and skid entry, then reset mid-stream.
    bus.o_ready = 1'b0;
    send(5, TW'(8'hA1));
    send(6, TW'(8'hA2));
    @(negedge clk);
    check_bit("skid_full_o_valid", bus.o_valid, 1'b1);
    check_bit("skid_full_i_ready", bus.i_ready, 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_bit("midreset_o_valid", bus.o_valid, 1'b0);
    check_outputs_zero("midreset_outputs");
    @(posedge clk);
    #2 reset = 1'b1;
    bus.o_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_bit("i_ready_after_midreset", bus.i_ready, 1'b1);
    check_bit("no_stale_beat", bus.o_valid, 1'b0);
    @(posedge clk);
    #1;

    send(1, TW'(8'hB0));
    send(7, TW'(8'hB1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_empty: %0d beats never emerged, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_add_align_stage.md
Name: fp_add_align_stage

Overview:
- Parametrised first stage of the FP add/subtract pipeline, generalised in format (exponent/significand width) and lane count.
- Per lane: classifies NaN/Inf, orders operands by magnitude, computes the alignment shift, and computes a sticky bit for the shifted-out bits, which the previous add stage does not provide.
- Adds a valid/ready handshake with a one-entry skid buffer, so upstream stalls propagate without losing data.
- Sits between operand fetch and the add-normalise stage of the float pipeline.

Parameters:
- NUM_LANES, 16, number of vector lanes.
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, stored significand width (hidden bit excluded).
- TAG_WIDTH, 8, opaque sideband carried alongside the data (thread index, subcycle).
- Derived, not overridable: FW = 1+EXP_WIDTH+SIG_WIDTH; MAX_SHIFT = SIG_WIDTH+4; SHW = $clog2(MAX_SHIFT+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  input transfer valid.
- i_ready  out  1  stage can accept.
- i_subtract  in  1  1 = op1-op2, 0 = op1+op2.
- i_mask  in  NUM_LANES  lane enable, passed through.
- i_tag  in  TAG_WIDTH  sideband, passed through.
- i_operand1  in  NUM_LANES*FW  packed operands, lane 0 in the LSBs.
- i_operand2  in  NUM_LANES*FW  packed operands.
- o_valid  out  1  output valid.
- o_ready  in  1  downstream accepts.
- o_mask  out  NUM_LANES  registered i_mask.
- o_tag  out  TAG_WIDTH  registered i_tag.
- o_significand_le  out  NUM_LANES*(SIG_WIDTH+1)  larger-magnitude significand, hidden bit included.
- o_significand_se  out  NUM_LANES*(SIG_WIDTH+1)  smaller-magnitude significand, unshifted.
- o_align_shift  out  NUM_LANES*SHW  right shift to apply to se.
- o_sticky  out  NUM_LANES  OR of se bits lost below the round bit.
- o_exponent  out  NUM_LANES*EXP_WIDTH  exponent of the larger operand.
- o_logical_subtract  out  NUM_LANES  sign1^sign2^i_subtract.
- o_result_sign  out  NUM_LANES  provisional result sign.
- o_result_nan  out  NUM_LANES  result is NaN.
- o_result_inf  out  NUM_LANES  result is ±Inf.

Behaviour:
- Reset (reset low, async): o_valid=0, skid buffer empty, every data/sideband output 0, i_ready=1 from the first edge after release.
- Handshake:
  - Input transfer when i_valid&&i_ready; output transfer when o_valid&&o_ready.
  - Outputs must hold stable while o_valid&&!o_ready.
  - Latency is one cycle: data accepted at edge N is on the outputs after edge N.
- Storage: one output register plus one skid entry.
  - i_ready = !skid_valid, a registered signal with no combinational path from o_ready.
  - Output register empty or draining this cycle: accepted data loads the output register directly.
  - Output register full and stalled: accepted data goes to the skid entry.
  - When the output register drains and the skid entry is full, the skid entry moves to the output register.
  - A simultaneous accept in that cycle is impossible because i_ready=0.
  - Order is preserved. No beat is lost or duplicated.
- Per lane (combinational, then registered):
  - hidden = (exp!=0). Full significand = {hidden, sig}.
  - op1_larger = exp1>exp2 || (exp1==exp2 && sig1>=sig2). Ties keep op1 in the le slot.
  - op1_larger: le=sig1, se=sig2, exponent=exp1, sign=sign1.
  - Otherwise: le=sig2, se=sig1, exponent=exp2, sign=sign2^i_subtract.
  - d = |exp1-exp2|; shift = min(d, MAX_SHIFT).
  - sticky: d<=2 gives 0; 3<=d<=MAX_SHIFT gives OR(se[d-3:0]); d>MAX_SHIFT gives OR(se).
  - nan = nan1 || nan2 || (inf1 && inf2 && logical_subtract).
  - inf = !nan && (inf1||inf2).
  - Inf is exp all-ones with sig 0; NaN is exp all-ones with sig nonzero.
- Masked-off lanes are still computed; the mask only passes through.
- Reset mid-stream discards the output register and skid contents immediately.

Decomposition:
- Shared package gains the float format typedef parameterised by EXP_WIDTH/SIG_WIDTH, plus a MAX_ALIGN_SHIFT helper function.
- One natural sub-module: fp_align_lane. It is purely combinational, holds the per-lane classify, swap, shift and sticky logic, and is instantiated NUM_LANES times in a generate loop.
- The top level holds the handshake, the output register and the skid buffer.

Test Plan:
- 0x3F800000 + 0x3F800000 → le=se=0x800000, shift 0, exponent 0x7F, sticky 0, sign 0, nan 0, inf 0.
- 0x3F800000 + 0x3D400001 (d=5) → shift 5, se=0xC00001, sticky 1. With 0x3D400000 instead → sticky 0.
- 0x3F800000 + 0x30800000 (d=30) → shift clamped to 27, sticky 1. 0x3F800000 − 0x40000000 → le=op2, exponent 0x80, sign 1, logical_subtract 1.
- 0x7F800000 − 0x7F800000 → nan 1, inf 0. 0x7F800000 + 0x7F800000 → inf 1. 0x7FC00000 + 1.0 → nan 1.
- Hold o_ready=0 for 3 cycles with i_valid=1 and tags 1,2,3,4 → i_ready falls after 2 accepts. Release → tags 1,2,3,4 emerge in order, each exactly once, with data stable during the stall.
- Assert reset while o_valid=1 and skid full → o_valid=0 and outputs 0 immediately. i_ready=1 after release. Nothing emitted from before the reset.
